// File: rtl/instr_mem_loadable_if.sv
// ---------------------------------------------------------------------------
// instr_mem_loadable_if: loader write port, CPU fetch port and status outputs
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface instr_mem_loadable_if #(
  parameter int DATA_WIDTH = 28,
  parameter int ADDR_WIDTH = 8
);
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  load_done;
  logic                  reload;
  logic                  fetch_valid;
  logic [ADDR_WIDTH-1:0] address;
  logic                  stall;
  logic [DATA_WIDTH-1:0] instruction;
  logic                  instruction_valid;
  logic                  ready;
  logic [ADDR_WIDTH:0]   load_count;

  modport master (
    output write_enable, write_address, write_data, load_done, reload,
    output fetch_valid, address, stall,
    input  instruction, instruction_valid, ready, load_count
  );

  modport slave (
    input  write_enable, write_address, write_data, load_done, reload,
    input  fetch_valid, address, stall,
    output instruction, instruction_valid, ready, load_count
  );
endinterface

`default_nettype wire

// File: rtl/instr_mem_loadable.sv
// ---------------------------------------------------------------------------
// instr_mem_loadable: loadable instruction memory with a registered fetch port
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_mem_loadable #(
  parameter int                    DATA_WIDTH   = 28,
  parameter int                    ADDR_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = DATA_WIDTH'('hAA)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_mem_loadable_if.slave  bus
);

  localparam int                  DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] COUNT_MAX = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] COUNT_ONE = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_written;
  logic [DATA_WIDTH-1:0] r_instruction;
  logic                  r_instruction_valid;
  logic                  r_ready;
  logic [ADDR_WIDTH:0]   r_load_count;
  logic [DATA_WIDTH-1:0] w_read_word;
  logic                  w_load_write;

  assign w_load_write = (r_state == ST_LOAD) && bus.write_enable;

  // Unwritten words are masked by the bitmap, so the array itself needs no reset.
  assign w_read_word = r_written[bus.address] ? r_mem[bus.address] : DEFAULT_WORD;

  always_ff @(posedge clk) begin
    if (w_load_write) begin
      r_mem[bus.write_address] <= bus.write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state             <= ST_LOAD;
      r_written           <= '0;
      r_instruction       <= DEFAULT_WORD;
      r_instruction_valid <= 1'b0;
      r_ready             <= 1'b0;
      r_load_count        <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_instruction_valid <= 1'b0;
          if (bus.write_enable) begin
            r_written[bus.write_address] <= 1'b1;
            if (r_load_count != COUNT_MAX) begin
              r_load_count <= r_load_count + COUNT_ONE;
            end
          end
          // A write in the same cycle as load_done still lands before RUN.
          if (bus.load_done) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.reload) begin
            r_state             <= ST_LOAD;
            r_ready             <= 1'b0;
            r_written           <= '0;
            r_load_count        <= '0;
            r_instruction_valid <= 1'b0;
          end else if (bus.stall) begin
            r_instruction_valid <= r_instruction_valid;
          end else if (bus.fetch_valid) begin
            r_instruction       <= w_read_word;
            r_instruction_valid <= 1'b1;
          end else begin
            r_instruction_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_LOAD;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instruction       = r_instruction;
  assign bus.instruction_valid = r_instruction_valid;
  assign bus.ready             = r_ready;
  assign bus.load_count        = r_load_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loadable.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_loadable: directed stimulus against a behavioural program model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instr_mem_loadable;

  localparam int          DW  = 28;
  localparam int          AW  = 8;
  localparam logic [27:0] DEF = 28'h00000AA;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  instr_mem_loadable_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  instr_mem_loadable #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .DEFAULT_WORD(DEF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: program held as a sparse map of written words.
  bit          m_run;
  int          m_count;
  logic [27:0] m_prog [int];
  logic [27:0] m_instr;
  bit          m_valid;

  task automatic model_reset();
    m_run   = 0;
    m_count = 0;
    m_prog.delete();
    m_instr = DEF;
    m_valid = 0;
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (rst_n) begin
      if (!m_run) begin
        if (bus.write_enable) begin
          m_prog[int'(bus.write_address)] = bus.write_data;
          if (m_count < 256) m_count++;
        end
        m_valid = 0;
        if (bus.load_done) m_run = 1;
      end else if (bus.reload) begin
        m_prog.delete();
        m_count = 0;
        m_valid = 0;
        m_run   = 0;
      end else if (!bus.stall) begin
        if (bus.fetch_valid) begin
          m_instr = m_prog.exists(int'(bus.address)) ? m_prog[int'(bus.address)] : DEF;
          m_valid = 1;
        end else begin
          m_valid = 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model.instruction", 32'(bus.instruction), 32'(m_instr));
    check("model.valid", 32'(bus.instruction_valid), 32'(m_valid));
    check("model.ready", 32'(bus.ready), 32'(m_run));
    check("model.load_count", 32'(bus.load_count), 32'(m_count));
  end

  task automatic idle();
    bus.write_enable  = 1'b0;
    bus.write_address = '0;
    bus.write_data    = '0;
    bus.load_done     = 1'b0;
    bus.reload        = 1'b0;
    bus.fetch_valid   = 1'b0;
    bus.address       = '0;
    bus.stall         = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic write_word(input logic [7:0] a, input logic [27:0] d);
    bus.write_enable  = 1'b1;
    bus.write_address = a;
    bus.write_data    = d;
    step();
  endtask

  task automatic fetch(input logic [7:0] a);
    bus.fetch_valid = 1'b1;
    bus.address     = a;
    step();
  endtask

  task automatic pulse_load_done();
    bus.load_done = 1'b1;
    step();
  endtask

  task automatic pulse_reload();
    bus.reload = 1'b1;
    step();
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.instruction", 32'(bus.instruction), 32'h00000AA);
    check("reset.valid", 32'(bus.instruction_valid), 0);
    check("reset.ready", 32'(bus.ready), 0);
    check("reset.count", 32'(bus.load_count), 0);
    rst_n = 1'b1;

    // Fetch in LOAD is ignored, then an unwritten address returns the default.
    fetch(8'h05);
    check("load_fetch.valid", 32'(bus.instruction_valid), 0);
    check("load_fetch.ready", 32'(bus.ready), 0);
    pulse_load_done();
    check("run.ready", 32'(bus.ready), 1);
    fetch(8'h05);
    check("unwritten.instr", 32'(bus.instruction), 32'h00000AA);
    check("unwritten.valid", 32'(bus.instruction_valid), 1);

    // Load two words and fetch back-to-back.
    pulse_reload();
    check("reload.count", 32'(bus.load_count), 0);
    write_word(8'h01, 28'h1234567);
    write_word(8'h02, 28'h89ABCDE);
    pulse_load_done();
    fetch(8'h01);
    check("b2b.0", 32'(bus.instruction), 32'h1234567);
    fetch(8'h02);
    check("b2b.1", 32'(bus.instruction), 32'h89ABCDE);
    check("b2b.valid", 32'(bus.instruction_valid), 1);
    fetch(8'h01);
    check("b2b.2", 32'(bus.instruction), 32'h1234567);
    check("b2b.count", 32'(bus.load_count), 2);

    // Stall holds the output register for three cycles.
    fetch(8'h01);
    for (int i = 0; i < 3; i++) begin
      bus.stall       = 1'b1;
      bus.fetch_valid = 1'b1;
      bus.address     = 8'h02;
      step();
      check("stall.instr", 32'(bus.instruction), 32'h1234567);
      check("stall.valid", 32'(bus.instruction_valid), 1);
    end
    fetch(8'h02);
    check("unstall.instr", 32'(bus.instruction), 32'h89ABCDE);

    // Reload together with a fetch drops the fetch and invalidates the program.
    bus.reload      = 1'b1;
    bus.fetch_valid = 1'b1;
    bus.address     = 8'h01;
    step();
    check("reload_fetch.valid", 32'(bus.instruction_valid), 0);
    check("reload_fetch.hold", 32'(bus.instruction), 32'h89ABCDE);
    check("reload_fetch.ready", 32'(bus.ready), 0);
    pulse_load_done();
    fetch(8'h01);
    check("invalidated.instr", 32'(bus.instruction), 32'h00000AA);

    // Write in the same cycle as load_done, then a write in RUN is ignored.
    pulse_reload();
    bus.load_done = 1'b1;
    write_word(8'h07, 28'h7654321);
    check("same_cycle.ready", 32'(bus.ready), 1);
    check("same_cycle.count", 32'(bus.load_count), 1);
    fetch(8'h07);
    check("same_cycle.instr", 32'(bus.instruction), 32'h7654321);
    write_word(8'h08, 28'h0FEDCBA);
    check("run_write.count", 32'(bus.load_count), 1);
    fetch(8'h08);
    check("run_write.instr", 32'(bus.instruction), 32'h00000AA);

    // 300 writes saturate the counter at 256.
    pulse_reload();
    for (int i = 0; i < 300; i++) begin
      write_word(8'(i), 28'(i + 28'h0100000));
      if (i == 254) check("sat.255", 32'(bus.load_count), 255);
    end
    check("sat.256", 32'(bus.load_count), 256);
    pulse_load_done();
    fetch(8'h03);
    check("sat.readback", 32'(bus.instruction), 32'h0100103);

    // Asynchronous reset between edges clears everything at once.
    bus.fetch_valid = 1'b1;
    bus.address     = 8'h04;
    #2;
    rst_n = 1'b0;
    #1;
    check("async.instr", 32'(bus.instruction), 32'h00000AA);
    check("async.valid", 32'(bus.instruction_valid), 0);
    check("async.ready", 32'(bus.ready), 0);
    check("async.count", 32'(bus.load_count), 0);
    idle();
    step();
    rst_n = 1'b1;
    pulse_load_done();
    fetch(8'h03);
    check("post_reset.instr", 32'(bus.instruction), 32'h00000AA);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
